output_queue: RTL and testbench

//   Per-output-port packet queue placed directly upstream of the router credit manager.

---
 rtl/output_queue.sv | 100 ++++++++++
 tb/tb_output_queue.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/output_queue.sv
// Per-port packet queue: FIFO plus output holding register, gated by the credit manager's can_send.
// Latency 2 edges from accepted input to out_valid; the held word is never retracted under out_ready backpressure.
module output_queue #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    input  logic                       can_send,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic                       outq_credit_return,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {IDLE, VALID} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              credit_q, credit_d;

    logic push, pop, xfer, load, fifo_empty;

    assign fifo_empty = (count_q == '0);
    assign in_ready   = (count_q != FULL);
    assign push       = in_valid & in_ready;
    assign xfer       = (state_q == VALID) & out_ready;
    // can_send is only consulted when the holding register is free or being vacated
    assign load       = !fifo_empty & can_send & ((state_q == IDLE) | xfer);
    assign pop        = load;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        out_data_d = out_data_q;
        credit_d   = xfer;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (load) out_data_d = mem_q[rd_ptr_q];

        case (state_q)
            IDLE:    if (load) state_d = VALID;
            VALID:   if (xfer && !load) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_data_q <= '0;
            credit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_data_q <= out_data_d;
            credit_q   <= credit_d;
        end
    end

    // Storage needs no reset: pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    assign out_valid          = (state_q == VALID);
    assign out_data           = out_data_q;
    assign outq_credit_return = credit_q;
    assign count              = count_q;
    assign empty              = fifo_empty;

endmodule

// File: tb/tb_output_queue.sv
// Randomized and directed bench for output_queue against a queue-based reference model.
module tb_output_queue;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              can_send = 1'b0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready = 1'b0;
    logic              outq_credit_return;
    logic [3:0]        count;
    logic              empty;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: buffered words, holding register and pending credit pulse
    logic [DATA_W-1:0] mq [$];
    bit                m_hv = 1'b0;
    logic [DATA_W-1:0] m_hd = '0;
    bit                m_cr = 1'b0;

    output_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .can_send(can_send),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .outq_credit_return(outq_credit_return),
        .count(count),
        .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_hv = 1'b0;
        m_hd = '0;
        m_cr = 1'b0;
    endtask

    task automatic model_edge(input bit iv, input logic [DATA_W-1:0] id, input bit cs, input bit ordy);
        bit tr, ld, pu;
        tr = m_hv && ordy;
        ld = (mq.size() > 0) && cs && (!m_hv || tr);
        pu = iv && (mq.size() < DEPTH);
        m_cr = tr;
        if (ld) begin
            m_hd = mq.pop_front();
            m_hv = 1'b1;
        end else if (tr) begin
            m_hv = 1'b0;
        end
        if (pu) mq.push_back(id);
    endtask

    task automatic check_all();
        chk("count",     64'(count),              64'(mq.size()));
        chk("empty",     64'(empty),              64'(mq.size() == 0));
        chk("in_ready",  64'(in_ready),           64'(mq.size() != DEPTH));
        chk("out_valid", 64'(out_valid),          64'(m_hv));
        chk("out_data",  out_data,                m_hd);
        chk("credit",    64'(outq_credit_return), 64'(m_cr));
    endtask

    task automatic step(input bit iv, input logic [DATA_W-1:0] id, input bit cs, input bit ordy);
        in_valid  = iv;
        in_data   = id;
        can_send  = cs;
        out_ready = ordy;
        @(posedge clk);
        model_edge(iv, id, cs, ordy);
        #1;
        check_all();
    endtask

    initial begin
        int pulses;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // T2 latency: two edges from presenting the word to out_valid
        step(1, 64'hA5, 1, 1);
        chk("t2_no_bypass", 64'(out_valid), 64'd0);
        step(0, 64'h0, 1, 1);
        chk("t2_valid", 64'(out_valid), 64'd1);
        chk("t2_data", out_data, 64'hA5);
        step(0, 64'h0, 1, 1);
        chk("t2_credit", 64'(outq_credit_return), 64'd1);
        step(0, 64'h0, 1, 1);
        chk("t2_credit_end", 64'(outq_credit_return), 64'd0);

        // T3 fill with can_send low, ninth word refused
        for (int i = 0; i < DEPTH; i++) step(1, 64'h100 + 64'(i), 0, 1);
        chk("t3_count", 64'(count), 64'(DEPTH));
        chk("t3_in_ready", 64'(in_ready), 64'd0);
        step(1, 64'hDEAD, 0, 1);
        chk("t3_count_9th", 64'(count), 64'(DEPTH));
        chk("t3_no_valid", 64'(out_valid), 64'd0);

        // T4 stream out eight words back-to-back
        pulses = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            step(0, 64'h0, 1, 1);
            if (outq_credit_return) pulses++;
        end
        chk("t4_pulses", 64'(pulses), 64'(DEPTH));
        chk("t4_count", 64'(count), 64'd0);
        chk("t4_idle", 64'(out_valid), 64'd0);

        // T5 backpressure with can_send toggling
        step(1, 64'hBEEF, 0, 0);
        step(0, 64'h0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 64'($urandom), i[0], 0);
            chk("t5_hold", out_data, 64'hBEEF);
            chk("t5_no_credit", 64'(outq_credit_return), 64'd0);
        end
        step(0, 64'h0, 0, 1);
        chk("t5_credit", 64'(outq_credit_return), 64'd1);
        for (int i = 0; i < DEPTH + 2; i++) step(0, 64'h0, 1, 1);

        // T6 simultaneous push/pop across pointer wrap
        for (int i = 0; i < 4; i++) step(1, 64'h600 + 64'(i), 0, 1);
        for (int i = 0; i < 3 * DEPTH; i++) begin
            step(1, 64'h700 + 64'(i), 1, 1);
            chk("t6_count", 64'(count), 64'd4);
        end
        for (int i = 0; i < DEPTH; i++) step(0, 64'h0, 1, 1);

        // Random traffic
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 3) != 0), {$urandom, $urandom},
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0));

        // T1 reset mid-stream, just after a transfer edge
        for (int i = 0; i < DEPTH + 2; i++) step(0, 64'h0, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 64'h900 + 64'(i), 0, 0);
        step(0, 64'h0, 1, 0);
        step(0, 64'h0, 0, 1);
        rst = 1'b1;
        #2;
        model_reset();
        check_all();
        chk("t1_count", 64'(count), 64'd0);
        chk("t1_credit", 64'(outq_credit_return), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(0, 64'h0, 1, 1);
            chk("t1_quiet", 64'(outq_credit_return), 64'd0);
        end

        for (int i = 0; i < 100; i++)
            step(($urandom_range(0, 1) != 0), {$urandom, $urandom},
                 ($urandom_range(0, 1) != 0), ($urandom_range(0, 1) != 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
